// File: rtl/muldiv_unit_if.sv
// Execute-stage multiply/divide port bundle: E-stage request side plus the HI/LO view.
// start is a one-cycle request pulse, honoured only while busy=0; busy stays high for the full op latency.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_out;
    logic        dbg_state;

    modport master (
        output start, op, rs_e, rt_e, hilo_sel,
        input  busy, hi, lo, hilo_out, dbg_state
    );

    modport slave (
        input  start, op, rs_e, rt_e, hilo_sel,
        output busy, hi, lo, hilo_out, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed at the start edge and parked in
// pending registers; a down-counter models the architectural latency before HI/LO commit.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_load;
    logic             w_done;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_busy;
    logic             w_is_md;
    logic             w_is_div;

    logic             w_signed;
    logic [63:0]      w_a_ext;
    logic [63:0]      w_b_ext;
    logic [63:0]      w_prod;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_b_safe;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_q;
    logic [31:0]      w_r;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    assign w_is_md  = ~bus.op[2];
    assign w_is_div = bus.op[1];

    // Signed ops use magnitudes so that 0x8000_0000 / -1 wraps to 0x8000_0000 without overflow.
    always_comb begin
        w_signed = ~bus.op[0];
        w_a_ext  = {{32{w_signed & bus.rs_e[31]}}, bus.rs_e};
        w_b_ext  = {{32{w_signed & bus.rt_e[31]}}, bus.rt_e};
        w_prod   = w_a_ext * w_b_ext;

        w_a_neg  = w_signed & bus.rs_e[31];
        w_b_neg  = w_signed & bus.rt_e[31];
        w_a_mag  = w_a_neg ? (~bus.rs_e + 32'd1) : bus.rs_e;
        w_b_mag  = w_b_neg ? (~bus.rt_e + 32'd1) : bus.rt_e;
        w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (w_is_div) begin
            if (bus.rt_e == 32'd0) begin
                w_res_hi = bus.rs_e;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_r;
                w_res_lo = w_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start && w_is_md) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(1))   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Requests arriving in RUN (including the completion cycle) are dropped here.
    always_comb begin
        w_load = 1'b0;
        w_mthi = 1'b0;
        w_mtlo = 1'b0;
        w_done = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = bus.start & w_is_md;
                w_mthi = bus.start & (bus.op == OP_MTHI);
                w_mtlo = bus.start & (bus.op == OP_MTLO);
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_done = (r_cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else if (w_load) begin
            r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
        end else if (w_busy) begin
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
        end else begin
            if (w_mthi) r_hi <= bus.rs_e;
            if (w_mtlo) r_lo <= bus.rs_e;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.hilo_out  = bus.hilo_sel ? r_hi : r_lo;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written corner sequences, random ops
// against a plain-arithmetic model of the HI/LO results.
module tb_muldiv_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int BUSY_LIMIT = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_len;
    } vec_t;

    vec_t        vecs[9];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] cur_hi,
                                              input logic [31:0] cur_lo);
        longint          sa, sb, q, r;
        longint unsigned pu;
        case (op)
            3'd0: begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa * sb;
                return q;
            end
            3'd1: begin
                pu = {32'h0, a} * {32'h0, b};
                return pu;
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
            3'd4:    return {a, cur_lo};
            3'd5:    return {cur_hi, a};
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op < 3'd2) return MULT_N;
        if (op < 3'd4) return DIV_N;
        return 0;
    endfunction

    // Issues one op, scrambles operands and hilo_sel while busy, optionally pokes start mid-run.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_len,
                          input bit intrude);
        logic [31:0] pre_hi, pre_lo;
        logic [63:0] exp;
        int          len;
        exp_q.push_back({e_hi, e_lo});
        pre_hi = m_hi;
        pre_lo = m_lo;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs_e  = a;
        bus.rt_e  = b;
        @(negedge clk);
        bus.start = 1'b0;
        len = 0;
        while (bus.busy === 1'b1 && len < BUSY_LIMIT) begin
            len++;
            chk("hold_hi", bus.hi, pre_hi);
            chk("hold_lo", bus.lo, pre_lo);
            bus.rs_e     = $urandom;
            bus.rt_e     = $urandom;
            bus.hilo_sel = 1'($urandom_range(0, 1));
            #1 chk("hilo_out_busy", bus.hilo_out, bus.hilo_sel ? pre_hi : pre_lo);
            if (intrude && (len == 2 || len == 5)) begin
                bus.start = 1'b1;
                bus.op    = (len == 2) ? 3'b010 : 3'b100;
                if (len == 5) bus.rs_e = 32'h0000_DEAD;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_len", 32'(len), 32'(e_len));
        exp = exp_q.pop_front();
        chk("result_hi", bus.hi, exp[63:32]);
        chk("result_lo", bus.lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        bus.hilo_sel = ~bus.hilo_sel;
        #1 chk("hilo_out_idle", bus.hilo_out, bus.hilo_sel ? m_hi : m_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [63:0] e;

        bus.start    = 1'b0;
        bus.op       = 3'b000;
        bus.rs_e     = '0;
        bus.rt_e     = '0;
        bus.hilo_sel = 1'b0;

        vecs[0] = '{3'b100, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         0};
        vecs[1] = '{3'b101, 32'hCAFE_0001, 32'h0,         32'h1234_5678, 32'hCAFE_0001, 0};
        vecs[2] = '{3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
        vecs[3] = '{3'b001, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, MULT_N};
        vecs[4] = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[5] = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_N};
        vecs[6] = '{3'b011, 32'h0000_0055, 32'h0,         32'h0000_0055, 32'hFFFF_FFFF, DIV_N};
        vecs[7] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_N};
        vecs[8] = '{3'b110, 32'h0000_0001, 32'h1,         32'h0,         32'h8000_0000, 0};

        #2 rst_n = 1'b0;
        #3;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_len, 1'b0);

        // DIV and MTHI poked during a MULT must be dropped, including in the completion cycle.
        run_op(3'b000, 32'd6, 32'd7, 32'h0, 32'd42, MULT_N, 1'b1);
        run_op(3'b111, 32'h5, 32'h5, 32'h0, 32'd42, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            case ($urandom_range(0, 4))
                0:       r_b = 32'h0;
                1:       r_b = 32'($urandom_range(1, 9));
                2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                default: r_b = $urandom;
            endcase
            e = ref_model(r_op, r_a, r_b, m_hi, m_lo);
            run_op(r_op, r_a, r_b, e[63:32], e[31:0], latency(r_op), 1'b0);
        end

        run_op(3'b100, 32'hFFFF_0000, 32'h0, 32'hFFFF_0000, m_lo, 0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.rs_e  = 32'd3;
        bus.rt_e  = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", 32'(bus.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_hi", bus.hi, 32'h0);
        chk("midrun_reset_lo", bus.lo, 32'h0);
        chk("midrun_reset_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abandoned_busy", 32'(bus.busy), 32'h0);
            chk("abandoned_hi", bus.hi, 32'h0);
            chk("abandoned_lo", bus.lo, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
